// File: rtl/uart_receiver.sv
// 8N1 UART receiver using 16x oversampling from an external baud tick.
// Recovers frames from an asynchronous serial line and strobes rx_done or frame_err.
module uart_receiver #(
    parameter int unsigned D       = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         rx_in,
    input  logic         baud_clk,
    output logic [D-1:0] data_out,
    output logic         rx_done,
    output logic         frame_err
);

    localparam int unsigned BW = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned TW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [D-1:0]    shreg_q, shreg_d;
    logic [D-1:0]    data_q, data_d;
    logic            rx_done_q, rx_done_d;
    logic            frame_err_q, frame_err_d;
    logic            sync1_q, sync1_d;
    logic            rx_sync_q, rx_sync_d;
    logic            rx_prev_q, rx_prev_d;
    logic            start_edge;
    logic            mid_start;
    logic            mid_bit;
    logic            last_bit;
    logic            stop_end;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_comb begin
        sync1_d   = rx_in;
        rx_sync_d = sync1_q;
        rx_prev_d = rx_sync_q;
    end

    assign start_edge = !rx_sync_q && rx_prev_q;
    assign mid_start  = baud_clk && (tick_q == TW'(7));
    assign mid_bit    = baud_clk && (tick_q == TW'(15));
    assign last_bit   = (bit_q == BW'(D - 1));
    assign stop_end   = baud_clk && (tick_q == TW'(SB_TICK - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_edge) state_d = START;
            START:   if (mid_start) state_d = rx_sync_q ? IDLE : DATA;
            DATA:    if (mid_bit && last_bit) state_d = STOP;
            STOP:    if (stop_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters, shift register and strobes; baud_clk low holds everything
    always_comb begin
        tick_d      = tick_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) tick_d = '0;
            end
            START: begin
                if (mid_start) begin
                    tick_d = '0;
                    if (!rx_sync_q) bit_d = '0;
                end else if (baud_clk) begin
                    tick_d = tick_q + TW'(1);
                end
            end
            DATA: begin
                if (mid_bit) begin
                    shreg_d = {rx_sync_q, shreg_q[D-1:1]};
                    tick_d  = '0;
                    if (!last_bit) bit_d = bit_q + BW'(1);
                end else if (baud_clk) begin
                    tick_d = tick_q + TW'(1);
                end
            end
            STOP: begin
                if (stop_end) begin
                    tick_d = '0;
                    if (rx_sync_q) begin
                        data_d    = shreg_q;
                        rx_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (baud_clk) begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                tick_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q      <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            sync1_q     <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
        end else begin
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            sync1_q     <= sync1_d;
            rx_sync_q   <= rx_sync_d;
            rx_prev_q   <= rx_prev_d;
        end
    end

    assign data_out  = data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver: single byte, back-to-back,
// false start, framing error with break, mid-frame reset and baud skew.
module tb_uart_receiver;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_in;
    logic       baud_clk = 1'b0;
    logic [7:0] data_out;
    logic       rx_done;
    logic       frame_err;
    logic [1:0] bcnt = 2'd0;

    int total = 0;
    int bad   = 0;
    int n_done = 0;
    int n_err  = 0;
    int n_both = 0;
    int n_spur = 0;
    logic [7:0] last_rx   = 8'h00;
    logic [7:0] last_data = 8'h00;

    uart_receiver #(.D(8), .SB_TICK(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_in     (rx_in),
        .baud_clk  (baud_clk),
        .data_out  (data_out),
        .rx_done   (rx_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // One-clk baud tick every 4 clk
    always @(posedge clk) begin
        bcnt     <= bcnt + 2'd1;
        baud_clk <= (bcnt == 2'd3);
    end

    // Strobe monitor sampled on the falling edge
    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            n_done++;
            last_rx = data_out;
        end
        if (frame_err === 1'b1) n_err++;
        if (rx_done === 1'b1 && frame_err === 1'b1) n_both++;
        if (reset_n === 1'b1 && data_out !== last_data && rx_done !== 1'b1) n_spur++;
        last_data = data_out;
    end

    task automatic hold(input logic v, input int n);
        rx_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int bc);
        hold(1'b0, bc);
        for (int i = 0; i < 8; i++) hold(b[i], bc);
        hold(stop_v, bc);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        rx_in   = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h want 0", data_out); end
        total++; if (rx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", rx_done); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", frame_err); end
        reset_n = 1'b1;
        hold(1'b1, 2 * BIT_CLKS);
    endtask

    task automatic test_single;
        int d0, e0;
        d0 = n_done; e0 = n_err;
        send_frame(8'hA5, 1'b1, BIT_CLKS);
        hold(1'b1, 16);
        total++; if (n_done - d0 != 1) begin bad++; $display("FAIL single_done_cnt: got %0d want 1", n_done - d0); end
        total++; if (last_rx !== 8'hA5) begin bad++; $display("FAIL single_strobe_data: got %0h want a5", last_rx); end
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL single_hold_data: got %0h want a5", data_out); end
        total++; if (n_err - e0 != 0) begin bad++; $display("FAIL single_err_cnt: got %0d want 0", n_err - e0); end
    endtask

    task automatic test_back_to_back;
        int d0, e0;
        logic [7:0] vec [3];
        vec[0] = 8'h00; vec[1] = 8'hFF; vec[2] = 8'h3C;
        d0 = n_done; e0 = n_err;
        for (int k = 0; k < 3; k++) begin
            send_frame(vec[k], 1'b1, BIT_CLKS);
            total++;
            if (last_rx !== vec[k]) begin
                bad++; $display("FAIL b2b_data[%0d]: got %0h want %0h", k, last_rx, vec[k]);
            end
        end
        hold(1'b1, 16);
        total++; if (n_done - d0 != 3) begin bad++; $display("FAIL b2b_done_cnt: got %0d want 3", n_done - d0); end
        total++; if (n_err - e0 != 0) begin bad++; $display("FAIL b2b_err_cnt: got %0d want 0", n_err - e0); end
    endtask

    task automatic test_false_start;
        int d0, e0;
        d0 = n_done; e0 = n_err;
        hold(1'b0, 20);
        hold(1'b1, 3 * BIT_CLKS);
        total++; if (n_done - d0 != 0) begin bad++; $display("FAIL false_done_cnt: got %0d want 0", n_done - d0); end
        total++; if (n_err - e0 != 0) begin bad++; $display("FAIL false_err_cnt: got %0d want 0", n_err - e0); end
        total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL false_data: got %0h want 3c", data_out); end
    endtask

    task automatic test_framing_break;
        int d0, e0;
        d0 = n_done; e0 = n_err;
        send_frame(8'h55, 1'b0, BIT_CLKS);
        hold(1'b0, 3 * 10 * BIT_CLKS);
        total++; if (n_err - e0 != 1) begin bad++; $display("FAIL ferr_err_cnt: got %0d want 1", n_err - e0); end
        total++; if (n_done - d0 != 0) begin bad++; $display("FAIL ferr_done_cnt: got %0d want 0", n_done - d0); end
        total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL ferr_data_held: got %0h want 3c", data_out); end
        hold(1'b1, 2 * BIT_CLKS);
        send_frame(8'h12, 1'b1, BIT_CLKS);
        hold(1'b1, 16);
        total++; if (n_done - d0 != 1) begin bad++; $display("FAIL after_break_done_cnt: got %0d want 1", n_done - d0); end
        total++; if (last_rx !== 8'h12) begin bad++; $display("FAIL after_break_data: got %0h want 12", last_rx); end
        total++; if (n_err - e0 != 1) begin bad++; $display("FAIL after_break_err_cnt: got %0d want 1", n_err - e0); end
    endtask

    task automatic test_reset_mid_frame;
        int d0, e0;
        logic [7:0] b;
        b = 8'hC3;
        d0 = n_done; e0 = n_err;
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) hold(b[i], BIT_CLKS);
        hold(b[4], BIT_CLKS / 2);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL midrst_data: got %0h want 0", data_out); end
        total++; if (rx_done !== 1'b0 || frame_err !== 1'b0) begin
            bad++; $display("FAIL midrst_strobes: got done=%b err=%b want 0 0", rx_done, frame_err);
        end
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        hold(1'b1, 4 * BIT_CLKS);
        total++; if (n_done - d0 != 0 || n_err - e0 != 0) begin
            bad++; $display("FAIL midrst_aborted: got done=%0d err=%0d want 0 0", n_done - d0, n_err - e0);
        end
        send_frame(8'h81, 1'b1, BIT_CLKS);
        hold(1'b1, 16);
        total++; if (n_done - d0 != 1) begin bad++; $display("FAIL midrst_done_cnt: got %0d want 1", n_done - d0); end
        total++; if (data_out !== 8'h81) begin bad++; $display("FAIL midrst_data_81: got %0h want 81", data_out); end
    endtask

    task automatic test_baud_skew;
        int d0, e0;
        int bcs [2];
        bcs[0] = 66; bcs[1] = 62;
        for (int k = 0; k < 2; k++) begin
            d0 = n_done; e0 = n_err;
            send_frame(8'h96, 1'b1, bcs[k]);
            hold(1'b1, 32);
            total++; if (n_done - d0 != 1) begin bad++; $display("FAIL skew%0d_done_cnt: got %0d want 1", bcs[k], n_done - d0); end
            total++; if (last_rx !== 8'h96) begin bad++; $display("FAIL skew%0d_data: got %0h want 96", bcs[k], last_rx); end
            total++; if (n_err - e0 != 0) begin bad++; $display("FAIL skew%0d_err_cnt: got %0d want 0", bcs[k], n_err - e0); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        rx_in   = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_false_start();
        test_framing_break();
        test_reset_mid_frame();
        test_baud_skew();
        total++; if (n_both != 0) begin bad++; $display("FAIL strobes_overlap: got %0d want 0", n_both); end
        total++; if (n_spur != 0) begin bad++; $display("FAIL data_changed_without_done: got %0d want 0", n_spur); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver. It is the receive-side counterpart of the team's UART transmitter, and it shares the same external baud rate generator tick (16× oversampling). The block recovers 8N1 frames from the asynchronous `rx_in` line. It presents each received byte on `data_out` with a single-cycle `rx_done` strobe, and reports a bad stop bit with a single-cycle `frame_err` strobe.

## Interface
- `D`, default 8: number of data bits per frame, sent LSB first.
- `SB_TICK`, default 16: oversampling ticks in the stop bit (16 means 1 stop bit).
- `clk`, input, 1: system clock. All state changes on its rising edge.
- `reset_n`, input, 1: reset. It is asynchronous and active-low.
- `rx_in`, input, 1: serial line. It is asynchronous to `clk` and idles high.
- `baud_clk`, input, 1: one-`clk`-wide tick at 16× the baud rate, from the baud rate generator.
- `data_out`, output, D: last correctly framed byte. It holds until the next good frame.
- `rx_done`, output, 1: one-cycle pulse when `data_out` is updated.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.

## Operation
- **Synchronizer**
  - `rx_in` passes through a 2-flop synchronizer to produce `rx_sync`.
  - `rx_sync` is also registered once more as `rx_prev`.
  - All three flops reset to 1.
  - All decisions use `rx_sync` only.
- **FSM states:** IDLE, START, DATA, STOP. Counters are `tick_cnt[3:0]` and `bit_cnt[$clog2(D)-1:0]`. The shift register is `shreg[D-1:0]`.
- **IDLE**
  - Start detection requires a falling edge: `rx_sync==0 && rx_prev==1`.
  - On detection: `tick_cnt`←0, go to START.
  - A line held low (break, or stuck after a framing error) never re-triggers the FSM.
- **START** (advances only when `baud_clk` is high)
  - If `tick_cnt==7`, this is mid start bit:
    - `rx_sync==0`: go to DATA, `tick_cnt`←0, `bit_cnt`←0.
    - `rx_sync==1`: this is a glitch; return to IDLE with no output activity.
  - Otherwise `tick_cnt`+1.
- **DATA** (on `baud_clk`)
  - If `tick_cnt==15`, this is mid bit:
    - `shreg`←{`rx_sync`, `shreg[D-1:1]`}, `tick_cnt`←0.
    - If `bit_cnt==D-1`, go to STOP; otherwise `bit_cnt`+1.
  - Otherwise `tick_cnt`+1.
- **STOP** (on `baud_clk`)
  - If `tick_cnt==SB_TICK-1`, go to IDLE, then:
    - `rx_sync==1`: `data_out`←`shreg`, pulse `rx_done`.
    - `rx_sync==0`: pulse `frame_err`; `data_out` is left unchanged.
  - Otherwise `tick_cnt`+1.
- **Arithmetic and priority**
  - `tick_cnt` wraps only by explicit clearing; it never exceeds 15.
  - `baud_clk` low freezes all counters, so state is held between ticks.
  - `rx_done` and `frame_err` are mutually exclusive and never high together.
- **Reset**
  - Asserting `reset_n` low at any time, including mid-frame, immediately forces:
    - the FSM to IDLE;
    - counters, `shreg`, `data_out` to 0;
    - `rx_done` and `frame_err` to 0;
    - the synchronizer flops to 1.
  - A partial frame is discarded.
  - After release, the next falling edge starts a fresh frame.

## Timing
- **Registered outputs.** All outputs are registered. Reset values: `data_out`=0, `rx_done`=0, `frame_err`=0.
- **Synchronizer delay.** A `rx_in` transition is visible on `rx_sync` 2 `clk` later. Start detection is registered on the 3rd edge after the line falls.
- **Sample points, counted in `baud_clk` ticks after entering START:**
  - start bit validated at tick 8;
  - data bit k sampled at tick 8+16(k+1);
  - stop bit sampled at tick 8+16·D+SB_TICK, which is 152 for the defaults.
- **Strobe timing.**
  - `rx_done` and `frame_err` go high in the `clk` cycle after the final stop tick edge, for exactly one `clk`.
  - `data_out` is valid in the same cycle `rx_done` is high, and is held afterwards.
- **Back-to-back frames.** A start edge arriving on the first IDLE cycle after STOP is accepted, so back-to-back frames need no idle gap beyond the stop bit.
- **Tolerance.** The receiver tolerates up to ±3% baud mismatch, because it samples mid-bit.

## Test plan
- **Single byte.**
  - Stimulus: reset low for 3 cycles, then release; send 0xA5 as 8N1 with `baud_clk` every 4 `clk` (64 `clk` per bit).
  - Expected: one `rx_done` pulse, `data_out`=0xA5, `frame_err` never high.
- **Back-to-back frames.**
  - Stimulus: 0x00, 0xFF, 0x3C with no idle gap.
  - Expected: three `rx_done` pulses with `data_out` equal to 0x00, 0xFF, 0x3C respectively.
- **False start.**
  - Stimulus: drive `rx_in` low for 5 ticks (20 `clk`), then high.
  - Expected: FSM returns to IDLE; no `rx_done`, no `frame_err`; `data_out` unchanged.
- **Framing error and break.**
  - Stimulus: send 0x55 with the stop bit low, then hold the line low for 3 frame times, then idle high, then send 0x12.
  - Expected:
    - exactly one `frame_err` pulse;
    - `data_out` keeps its previous value during the error and the break;
    - no further strobes while the line is held low;
    - 0x12 is then received with `rx_done`.
- **Reset mid-frame.**
  - Stimulus: assert `reset_n` low during data bit 4 of 0xC3; release; send 0x81.
  - Expected:
    - `data_out`=0 and the strobes are low while reset is asserted;
    - no strobe results from the aborted frame;
    - 0x81 is received correctly.
- **Baud skew.**
  - Stimulus: transmit 0x96 at +3% and again at −3% bit period.
  - Expected: both received as 0x96 with `rx_done` and no `frame_err`.
